// File: rtl/trace_buffer.sv
// trace_buffer: ping-pong column store between the ray tracer and the VGA pixel path.
// The tracer fills the back bank while the display reads the front bank. The banks swap
// at frame start once the back bank holds a complete trace. The read path has two cycles
// of latency and produces wall and side flags for each pixel.
// Optional feature: define TRACE_BUFFER_DROP_COUNT_EN to add an 8-bit saturating
// drop_count output that counts frame starts which did not swap.
module trace_buffer #(
    parameter int unsigned COLS   = 640,
    parameter int unsigned HALF_H = 240,
    parameter int unsigned HW     = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [9:0]    wr_col,
    input  logic          wr_side,
    input  logic [HW-1:0] wr_height,
    input  logic          wr_done,
    input  logic [9:0]    h,
    input  logic [9:0]    v,
    input  logic          frame_start,
    output logic          trace_en,
    output logic          pix_wall,
    output logic          pix_side,
    output logic          front_valid
`ifdef TRACE_BUFFER_DROP_COUNT_EN
    ,
    output logic [7:0]    drop_count
`endif
);

    localparam int unsigned CW    = 10;        // column / row counter width
    localparam int unsigned AW    = 11;        // flat RAM address width (2 banks)
    localparam int unsigned VW    = 11;        // vertical compare width
    localparam int unsigned WW    = HW + 1;    // stored word: {side, height}
    localparam int unsigned DEPTH = 2 * COLS;

    // Both banks share one array; bank 1 lives at offset COLS.
    logic [WW-1:0] mem [0:DEPTH-1];

    logic          bankSel;
    logic          backDone;
    logic          swap;
    logic          wrOk;
    logic [AW-1:0] wrAddr;
    logic [AW-1:0] rdAddr;
    logic [HW-1:0] wrHeightClamped;
    logic [WW-1:0] rdWordC;

    logic          rdSide;
    logic [HW-1:0] rdHt;
    logic [CW-1:0] rdV;

    logic [HW-1:0] htClamped;
    logic [VW-1:0] lowRow;
    logic [VW-1:0] highRow;
    logic          wallC;

    // Swap decision, write qualification and RAM addressing.
    always_comb begin
        swap            = frame_start && (backDone || wr_done);
        wrOk            = wr_en && (wr_col < CW'(COLS)) && !swap;
        wrHeightClamped = (wr_height > HW'(HALF_H)) ? HW'(HALF_H) : wr_height;
        wrAddr          = (bankSel ? AW'(0) : AW'(COLS)) + AW'(wr_col);
        rdAddr          = (bankSel ? AW'(COLS) : AW'(0)) + AW'(h);
        rdWordC         = '0;
        if (h < CW'(COLS)) begin
            rdWordC = mem[rdAddr];
        end
    end

    // Bank selection, completion flag, front validity and tracer enable.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bankSel     <= 1'b0;
            backDone    <= 1'b0;
            front_valid <= 1'b0;
            trace_en    <= 1'b0;
        end else begin
            trace_en <= !swap;
            if (swap) begin
                bankSel     <= ~bankSel;
                backDone    <= 1'b0;
                front_valid <= 1'b1;
            end else if (wr_done) begin
                backDone <= 1'b1;
            end
        end
    end

    // Back-bank write port; RAM contents are left alone by reset.
    always_ff @(posedge clk) begin
        if (reset_n && wrOk) begin
            mem[wrAddr] <= {wr_side, wrHeightClamped};
        end
    end

    // Read stage 1: register the front-bank word and the row.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdSide <= 1'b0;
            rdHt   <= '0;
            rdV    <= '0;
        end else begin
            rdSide <= rdWordC[WW-1];
            rdHt   <= rdWordC[HW-1:0];
            rdV    <= v;
        end
    end

    // Wall span test around the vertical centre.
    always_comb begin
        htClamped = (rdHt > HW'(HALF_H)) ? HW'(HALF_H) : rdHt;
        lowRow    = VW'(HALF_H) - VW'(htClamped);
        highRow   = VW'(HALF_H) + VW'(htClamped);
        wallC     = front_valid && (htClamped != '0) &&
                    (VW'(rdV) >= lowRow) && (VW'(rdV) < highRow);
    end

    // Read stage 2: registered pixel outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pix_wall <= 1'b0;
            pix_side <= 1'b0;
        end else begin
            pix_wall <= wallC;
            pix_side <= wallC && rdSide;
        end
    end

`ifdef TRACE_BUFFER_DROP_COUNT_EN
    // Saturating count of frame starts that re-showed the old front bank.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (frame_start && !swap && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule
